// File: rtl/decode_stage_riscv.sv
// RV32I decode stage (optional M / Zicsr) with registered outputs and a 2-entry skid buffer.
// state | meaning
// EMPTY | nothing held, outputs invalid
// ONE   | main register holds the entry presented to execute
// TWO   | main and skid both full, fetch is stalled
module decode_stage_riscv #(
    parameter int unsigned PC_W     = 32,
    parameter bit          M_EXT_EN = 1'b0,
    parameter bit          CSR_EN   = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            flush_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [PC_W-1:0] dec_pc_o,
    output logic [31:0]     dec_instr_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic [1:0]      a_sel_o,
    output logic [2:0]      b_sel_o,
    output logic [4:0]      alu_op_o,
    output logic            mdu_req_o,
    output logic [2:0]      mdu_op_o,
    output logic [2:0]      csr_op_o,
    output logic            csr_we_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [2:0]      mem_size_o,
    output logic            gpr_we_o,
    output logic [1:0]      wb_sel_o,
    output logic            branch_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic            mret_o,
    output logic            ecall_o,
    output logic            ebreak_o,
    output logic            illegal_instr_o
);
    localparam logic [6:0] OPC_LOAD = 7'h03, OPC_MISC_MEM = 7'h0F, OPC_OP_IMM = 7'h13,
                           OPC_AUIPC = 7'h17, OPC_STORE = 7'h23, OPC_OP = 7'h33, OPC_LUI = 7'h37,
                           OPC_BRANCH = 7'h63, OPC_JALR = 7'h67, OPC_JAL = 7'h6F, OPC_SYSTEM = 7'h73;
    localparam logic [1:0] A_RS1 = 2'd0, A_CURR_PC = 2'd1, A_ZERO = 2'd2;
    localparam logic [2:0] B_RS2 = 3'd0, B_IMM_I = 3'd1, B_IMM_U = 3'd2, B_IMM_S = 3'd3, B_INCR = 3'd4;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_XOR = 5'd2, ALU_OR = 5'd3,
                           ALU_AND = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                           ALU_SLT = 5'd8, ALU_SLTU = 5'd9, ALU_EQ = 5'd10, ALU_NE = 5'd11,
                           ALU_LT = 5'd12, ALU_GE = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15;
    localparam logic [1:0] WB_EX = 2'd0, WB_LSU = 2'd1, WB_CSR = 2'd2, WB_MDU = 2'd3;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [1:0]      a_sel;
        logic [2:0]      b_sel;
        logic [4:0]      alu_op;
        logic            mdu_req;
        logic [2:0]      mdu_op;
        logic [2:0]      csr_op;
        logic            csr_we;
        logic            mem_req;
        logic            mem_we;
        logic [2:0]      mem_size;
        logic            gpr_we;
        logic [1:0]      wb_sel;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            mret;
        logic            ecall;
        logic            ebreak;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;

    state_e      state_q, state_d;
    entry_t      dec_entry, main_q, main_d, skid_q, skid_d;
    logic        ill, accept;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_entry       = '0;
        dec_entry.pc    = pc_i;
        dec_entry.instr = instr_i;
        ill             = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_entry.a_sel  = A_ZERO;
                dec_entry.b_sel  = B_IMM_U;
                dec_entry.gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_entry.a_sel  = A_CURR_PC;
                dec_entry.b_sel  = B_IMM_U;
                dec_entry.gpr_we = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_entry.a_sel  = A_CURR_PC;
                dec_entry.b_sel  = B_INCR;
                dec_entry.gpr_we = 1'b1;
                dec_entry.jal    = (opcode == OPC_JAL);
                dec_entry.jalr   = (opcode == OPC_JALR);
                ill              = (opcode == OPC_JALR) && (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_entry.branch = 1'b1;
                case (funct3)
                    3'b000:  dec_entry.alu_op = ALU_EQ;
                    3'b001:  dec_entry.alu_op = ALU_NE;
                    3'b100:  dec_entry.alu_op = ALU_LT;
                    3'b101:  dec_entry.alu_op = ALU_GE;
                    3'b110:  dec_entry.alu_op = ALU_LTU;
                    3'b111:  dec_entry.alu_op = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_entry.b_sel    = B_IMM_I;
                dec_entry.mem_req  = 1'b1;
                dec_entry.mem_size = funct3;
                dec_entry.gpr_we   = 1'b1;
                dec_entry.wb_sel   = WB_LSU;
                ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_entry.b_sel    = B_IMM_S;
                dec_entry.mem_req  = 1'b1;
                dec_entry.mem_we   = 1'b1;
                dec_entry.mem_size = funct3;
                ill = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                dec_entry.b_sel  = B_IMM_I;
                dec_entry.gpr_we = 1'b1;
                dec_entry.alu_op = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
                ill = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                      ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                if (funct7 == 7'h01) begin
                    dec_entry.mdu_req = 1'b1;
                    dec_entry.mdu_op  = funct3;
                    dec_entry.gpr_we  = 1'b1;
                    dec_entry.wb_sel  = WB_MDU;
                    ill = !M_EXT_EN;
                end else begin
                    dec_entry.gpr_we = 1'b1;
                    dec_entry.alu_op = alu_of(funct3, funct7[5]);
                    ill = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                end
            end
            OPC_MISC_MEM: ill = (funct3 != 3'b000);
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    dec_entry.ecall  = (instr_i == 32'h0000_0073);
                    dec_entry.ebreak = (instr_i == 32'h0010_0073);
                    dec_entry.mret   = (instr_i == 32'h3020_0073);
                    ill = !(dec_entry.ecall || dec_entry.ebreak || dec_entry.mret);
                end else begin
                    dec_entry.csr_op = funct3;
                    // set/clear with a zero source leave the CSR untouched
                    dec_entry.csr_we = (funct3[1:0] == 2'b01) || (instr_i[19:15] != 5'd0);
                    dec_entry.gpr_we = 1'b1;
                    dec_entry.wb_sel = WB_CSR;
                    ill = !CSR_EN || (funct3 == 3'b100);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec_entry         = '0;
            dec_entry.pc      = pc_i;
            dec_entry.instr   = instr_i;
            dec_entry.illegal = 1'b1;
        end
    end

    assign instr_ready_o = (state_q != S_TWO);
    assign accept        = instr_valid_i & instr_ready_o & ~flush_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) begin
                    main_d  = dec_entry;
                    state_d = S_ONE;
                end
                S_ONE: if (dec_ready_i) begin
                    if (accept) main_d = dec_entry;
                    else        state_d = S_EMPTY;
                end else if (accept) begin
                    skid_d  = dec_entry;
                    state_d = S_TWO;
                end
                S_TWO: if (dec_ready_i) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign dec_valid_o     = (state_q != S_EMPTY);
    assign dec_pc_o        = main_q.pc;
    assign dec_instr_o     = main_q.instr;
    assign rs1_addr_o      = main_q.instr[19:15];
    assign rs2_addr_o      = main_q.instr[24:20];
    assign rd_addr_o       = main_q.instr[11:7];
    assign a_sel_o         = main_q.a_sel;
    assign b_sel_o         = main_q.b_sel;
    assign alu_op_o        = main_q.alu_op;
    assign mdu_op_o        = main_q.mdu_op;
    assign csr_op_o        = main_q.csr_op;
    assign mem_size_o      = main_q.mem_size;
    assign wb_sel_o        = main_q.wb_sel;
    assign mdu_req_o       = dec_valid_o & main_q.mdu_req;
    assign csr_we_o        = dec_valid_o & main_q.csr_we;
    assign mem_req_o       = dec_valid_o & main_q.mem_req;
    assign mem_we_o        = dec_valid_o & main_q.mem_we;
    assign gpr_we_o        = dec_valid_o & main_q.gpr_we;
    assign branch_o        = dec_valid_o & main_q.branch;
    assign jal_o           = dec_valid_o & main_q.jal;
    assign jalr_o          = dec_valid_o & main_q.jalr;
    assign mret_o          = dec_valid_o & main_q.mret;
    assign ecall_o         = dec_valid_o & main_q.ecall;
    assign ebreak_o        = dec_valid_o & main_q.ebreak;
    assign illegal_instr_o = dec_valid_o & main_q.illegal;
endmodule

// File: tb/tb_decode_stage_riscv.sv
// Randomised bench for decode_stage_riscv: three configurations share stimulus and are
// checked each cycle against a queue-based reference of the stage.
module tb_decode_stage_riscv;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  a_sel;
        logic [2:0]  b_sel;
        logic [4:0]  alu_op;
        logic        mdu_req;
        logic [2:0]  mdu_op;
        logic [2:0]  csr_op;
        logic        csr_we;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        gpr_we;
        logic [1:0]  wb_sel;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mret;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni, instr_valid_i, flush_i, dec_ready_i;
    logic [31:0] instr_i, pc_i;
    dec_t        outs [3];
    logic        vld [3];
    logic        rdy [3];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] qi [$];
    logic [31:0] qp [$];
    string       names [3] = '{"base", "mext", "nocsr"};

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam bit M_EN = (g == 1);
        localparam bit C_EN = (g != 2);
        logic [31:0] pc_w, instr_w;
        logic [4:0]  rs1_w, rs2_w, rd_w, alu_w;
        logic [1:0]  a_w, wb_w;
        logic [2:0]  b_w, mop_w, cop_w, size_w;
        logic        v_w, r_w, mreq_w, cwe_w, lreq_w, lwe_w, gwe_w;
        logic        br_w, jal_w, jalr_w, mret_w, ecall_w, ebreak_w, ill_w;
        decode_stage_riscv #(.PC_W(32), .M_EXT_EN(M_EN), .CSR_EN(C_EN)) u_dut (
            .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .instr_ready_o(r_w),
            .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .dec_valid_o(v_w),
            .dec_ready_i(dec_ready_i), .dec_pc_o(pc_w), .dec_instr_o(instr_w),
            .rs1_addr_o(rs1_w), .rs2_addr_o(rs2_w), .rd_addr_o(rd_w), .a_sel_o(a_w),
            .b_sel_o(b_w), .alu_op_o(alu_w), .mdu_req_o(mreq_w), .mdu_op_o(mop_w),
            .csr_op_o(cop_w), .csr_we_o(cwe_w), .mem_req_o(lreq_w), .mem_we_o(lwe_w),
            .mem_size_o(size_w), .gpr_we_o(gwe_w), .wb_sel_o(wb_w), .branch_o(br_w),
            .jal_o(jal_w), .jalr_o(jalr_w), .mret_o(mret_w), .ecall_o(ecall_w),
            .ebreak_o(ebreak_w), .illegal_instr_o(ill_w));
        assign outs[g] = {pc_w, instr_w, rs1_w, rs2_w, rd_w, a_w, b_w, alu_w, mreq_w, mop_w,
                          cop_w, cwe_w, lreq_w, lwe_w, size_w, gwe_w, wb_w, br_w, jal_w,
                          jalr_w, mret_w, ecall_w, ebreak_w, ill_w};
        assign vld[g] = v_w;
        assign rdy[g] = r_w;
    end

    function automatic logic [11:0] flags_of(input dec_t d);
        return {d.gpr_we, d.mem_req, d.mem_we, d.csr_we, d.mdu_req, d.branch,
                d.jal, d.jalr, d.mret, d.ecall, d.ebreak, d.illegal};
    endfunction

    // Reference decode: a = 0 RS1/1 PC/2 ZERO; b = 0 RS2/1 I/2 U/3 S/4 INCR;
    // alu = ADD SUB XOR OR AND SLL SRL SRA SLT SLTU EQ NE LT GE LTU GEU (0..15)
    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input bit m_en, input bit c_en);
        dec_t d;
        bit ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] alu_tbl [8] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd2, 5'd6, 5'd3, 5'd4};
        logic [4:0] br_tbl  [8] = '{5'd10, 5'd11, 5'd0, 5'd0, 5'd12, 5'd13, 5'd14, 5'd15};
        d = '0; ok = 1; f3 = w[14:12]; f7 = w[31:25];
        case (w[6:0])
            7'h37: begin d.a_sel = 2; d.b_sel = 2; d.gpr_we = 1; end
            7'h17: begin d.a_sel = 1; d.b_sel = 2; d.gpr_we = 1; end
            7'h6F: begin d.jal = 1; d.a_sel = 1; d.b_sel = 4; d.gpr_we = 1; end
            7'h67: begin ok = (f3 == 0); d.jalr = 1; d.a_sel = 1; d.b_sel = 4; d.gpr_we = 1; end
            7'h63: begin ok = (f3 != 2) && (f3 != 3); d.branch = 1; d.alu_op = br_tbl[f3]; end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                d.mem_req = 1; d.gpr_we = 1; d.wb_sel = 1; d.mem_size = f3; d.b_sel = 1;
            end
            7'h23: begin ok = (f3 < 3); d.mem_req = 1; d.mem_we = 1; d.b_sel = 3; d.mem_size = f3; end
            7'h13: begin
                d.b_sel = 1; d.gpr_we = 1; d.alu_op = alu_tbl[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) d.alu_op = 7;
                    else ok = (f7 == 0);
                end
            end
            7'h33: begin
                d.gpr_we = 1;
                if (f7 == 7'h01) begin ok = m_en; d.mdu_req = 1; d.mdu_op = f3; d.wb_sel = 3; end
                else if (f7 == 7'h00) d.alu_op = alu_tbl[f3];
                else if (f7 == 7'h20 && f3 == 0) d.alu_op = 1;
                else if (f7 == 7'h20 && f3 == 5) d.alu_op = 7;
                else ok = 0;
            end
            7'h0F: ok = (f3 == 0);
            7'h73: begin
                if (f3 == 0) begin
                    if (w == 32'h0000_0073) d.ecall = 1;
                    else if (w == 32'h0010_0073) d.ebreak = 1;
                    else if (w == 32'h3020_0073) d.mret = 1;
                    else ok = 0;
                end else begin
                    ok = c_en && (f3 != 4);
                    d.csr_op = f3; d.gpr_we = 1; d.wb_sel = 2;
                    d.csr_we = (f3[1:0] == 2'b01) || (w[19:15] != 0);
                end
            end
            default: ok = 0;
        endcase
        if (!ok) begin d = '0; d.illegal = 1; end
        d.pc = pc; d.instr = w; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
        return d;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_update();
        bit acc;
        acc = instr_valid_i && (qi.size() < 2) && !flush_i;
        if (flush_i) begin
            qi.delete(); qp.delete();
        end else begin
            if (dec_ready_i && qi.size() > 0) begin void'(qi.pop_front()); void'(qp.pop_front()); end
            if (acc) begin qi.push_back(instr_i); qp.push_back(pc_i); end
        end
    endtask

    task automatic compare_all();
        logic ev, er;
        ev = (qi.size() > 0);
        er = (qi.size() < 2);
        for (int g = 0; g < 3; g++) begin
            chk({names[g], " handshake"}, 128'({vld[g], rdy[g]}), 128'({ev, er}));
            if (ev) chk({names[g], " decode"}, 128'(outs[g]), 128'(ref_decode(qi[0], qp[0], g == 1, g != 2)));
            else    chk({names[g], " idle flags"}, 128'(flags_of(outs[g])), 128'(0));
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] sys [4]  = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073};
        logic [6:0]  f7s [3]  = '{7'h00, 7'h20, 7'h01};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        if ($urandom_range(0, 9) == 0) return sys[$urandom_range(0, 3)];
        w[6:0] = opc[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
        return w;
    endfunction

    initial begin
        rst_ni = 0; instr_valid_i = 0; flush_i = 0; dec_ready_i = 0; instr_i = 0; pc_i = 0;
        #12;
        for (int g = 0; g < 3; g++) begin
            chk("reset handshake", 128'({vld[g], rdy[g]}), 128'(2'b01));
            chk("reset outputs", 128'(outs[g]), 128'(0));
        end
        @(negedge clk_i);
        rst_ni = 1;

        // pin the reference model on a few hand-decoded words
        chk("model addi b_sel", 128'(ref_decode(32'h0050_0093, 0, 0, 1).b_sel), 128'(1));
        chk("model lw size", 128'(ref_decode(32'h0000_A283, 0, 0, 1).mem_size), 128'(2));
        chk("model sub alu", 128'(ref_decode(32'h4020_81B3, 0, 0, 1).alu_op), 128'(1));
        chk("model mul off", 128'(ref_decode(32'h0220_81B3, 0, 0, 1).illegal), 128'(1));

        pc_i = 32'h100; instr_i = 32'h0050_0093; instr_valid_i = 1; dec_ready_i = 1;
        step();
        chk("addi valid", 128'(vld[0]), 128'(1));
        chk("addi alu_op", 128'(outs[0].alu_op), 128'(0));
        chk("addi b_sel", 128'(outs[0].b_sel), 128'(1));
        chk("addi gpr_we", 128'(outs[0].gpr_we), 128'(1));
        chk("addi rd", 128'(outs[0].rd), 128'(1));
        chk("addi pc", 128'(outs[0].pc), 128'(32'h100));
        instr_i = 32'h0220_81B3;
        step();
        chk("mul mdu_req", 128'(outs[1].mdu_req), 128'(1));
        chk("mul mdu_op", 128'(outs[1].mdu_op), 128'(0));
        chk("mul wb_sel", 128'(outs[1].wb_sel), 128'(3));
        chk("mul off illegal", 128'(outs[0].illegal), 128'(1));
        chk("mul off gpr_we", 128'(outs[0].gpr_we), 128'(0));
        instr_valid_i = 0;
        step();

        dec_ready_i = 0; instr_valid_i = 1; instr_i = 32'h0000_A283; pc_i = 32'h200;
        step();
        instr_i = 32'h0020_81B3; pc_i = 32'h204;
        step();
        instr_i = 32'h0000_0013; pc_i = 32'h208;
        step();
        chk("bp ready", 128'(rdy[0]), 128'(0));
        chk("bp hold instr", 128'(outs[0].instr), 128'(32'h0000_A283));
        chk("bp mem_size", 128'(outs[0].mem_size), 128'(2));
        chk("bp wb_sel", 128'(outs[0].wb_sel), 128'(1));
        dec_ready_i = 1; instr_valid_i = 0;
        step();
        chk("bp add next", 128'(outs[0].instr), 128'(32'h0020_81B3));
        chk("bp ready again", 128'(rdy[0]), 128'(1));
        step();
        chk("bp drained", 128'(vld[0]), 128'(0));

        dec_ready_i = 0; instr_valid_i = 1;
        step();
        step();
        flush_i = 1; instr_i = 32'h0010_0093;
        step();
        chk("flush valid", 128'(vld[0]), 128'(0));
        chk("flush flags", 128'(flags_of(outs[0])), 128'(0));
        flush_i = 0; instr_valid_i = 0;
        step();
        chk("flush not accepted", 128'(vld[0]), 128'(0));

        dec_ready_i = 1; instr_valid_i = 1;
        instr_i = 32'h0000_0073; step(); chk("ecall", 128'(outs[0].ecall), 128'(1));
        instr_i = 32'h0010_0073; step(); chk("ebreak", 128'(outs[0].ebreak), 128'(1));
        instr_i = 32'h3020_0073; step(); chk("mret", 128'(outs[0].mret), 128'(1));
        instr_i = 32'h1050_0073; step(); chk("wfi illegal", 128'(outs[0].illegal), 128'(1));
        instr_i = 32'h3000_1073; step();
        chk("csr off illegal", 128'(outs[2].illegal), 128'(1));
        chk("csr off csr_we", 128'(outs[2].csr_we), 128'(0));
        chk("csr on csr_we", 128'(outs[0].csr_we), 128'(1));
        chk("csr on wb_sel", 128'(outs[0].wb_sel), 128'(2));
        instr_valid_i = 0;
        step();

        dec_ready_i = 0; instr_valid_i = 1; instr_i = 32'h0050_0093;
        step();
        #2 rst_ni = 0; instr_valid_i = 0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("async reset valid", 128'(vld[g]), 128'(0));
            chk("async reset outputs", 128'(outs[g]), 128'(0));
        end
        #1 rst_ni = 1;
        qi.delete(); qp.delete();
        step();
        chk("post reset ready", 128'(rdy[0]), 128'(1));

        for (int i = 0; i < 3000; i++) begin
            instr_valid_i = ($urandom_range(0, 3) != 0);
            dec_ready_i   = ($urandom_range(0, 4) < 3);
            flush_i       = ($urandom_range(0, 19) == 0);
            instr_i       = rand_instr();
            pc_i          = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_stage_riscv.md
Name: decode_stage_riscv

Overview:
Registered RV32I decode stage that sits between fetch and execute. It accepts an instruction and PC over a valid/ready handshake, decodes it into datapath control fields, and presents them registered to execute. Decode is generalised over the single-cycle decoder: optional M-extension (MDU) and Zicsr decoding, plus ECALL/EBREAK detection. A 2-entry skid buffer keeps instr_ready_o free of any combinational path from dec_ready_i, and a flush input kills in-flight entries.

Parameters:
PC_W, 32, width of pc_i / dec_pc_o
M_EXT_EN, 0, 1 = decode MUL/DIV group (OP opcode, funct7=0000001); 0 = these instructions are illegal
CSR_EN, 1, 1 = decode CSR* instructions; 0 = SYSTEM funct3!=000 is illegal

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_valid_i  in  1  fetch offers instruction
instr_ready_o  out  1  stage can accept an instruction
instr_i  in  32  fetched instruction
pc_i  in  PC_W  PC of instr_i
flush_i  in  1  kill all held entries
dec_valid_o  out  1  decoded entry valid
dec_ready_i  in  1  execute consumes entry
dec_pc_o  out  PC_W  PC of entry
dec_instr_o  out  32  raw instruction of entry (immediate generation)
rs1_addr_o / rs2_addr_o / rd_addr_o  out  5 each  instr[19:15] / [24:20] / [11:7]
a_sel_o  out  2  ALU operand A select (RS1/CURR_PC/ZERO)
b_sel_o  out  3  ALU operand B select (RS2/IMM_I/IMM_U/IMM_S/INCR)
alu_op_o  out  5  ALU operation
mdu_req_o  out  1  MDU operation request
mdu_op_o  out  3  MDU operation (= funct3)
csr_op_o  out  3  CSR operation
csr_we_o  out  1  CSR write enable
mem_req_o / mem_we_o  out  1 each  LSU request / write
mem_size_o  out  3  LSU size (LDST_B/H/W/BU/HU)
gpr_we_o  out  1  register file write enable
wb_sel_o  out  2  0 EX_RESULT, 1 LSU_DATA, 2 CSR_DATA, 3 MDU_RESULT
branch_o / jal_o / jalr_o / mret_o  out  1 each  control transfer flags
ecall_o / ebreak_o  out  1 each  environment call / breakpoint
illegal_instr_o  out  1  illegal instruction

Behaviour:
- Decode is combinational on instr_i and registered on acceptance. Accept = instr_valid_i & instr_ready_o & ~flush_i. Latency 1: an entry accepted at edge N drives dec_valid_o=1 after edge N.
- Decode table: RV32I as in the current decoder (LOAD/STORE size checks, OP/OP_IMM funct3/funct7 checks, branch funct3, JALR funct3=000, FENCE funct3=000 is a legal NOP, instr[1:0]!=11 is illegal).
- SYSTEM: 0x30200073 -> mret_o; 0x00000073 -> ecall_o; 0x00100073 -> ebreak_o; any other funct3=000 word is illegal. CSR group follows CSR_EN.
- MDU group (M_EXT_EN=1): mdu_req_o=1, mdu_op_o=funct3, gpr_we_o=1, wb_sel_o=3, a_sel=RS1, b_sel=RS2.
- Illegal entry: illegal_instr_o=1; gpr_we, mem_req, mem_we, csr_we, mdu_req, branch, jal, jalr, mret, ecall and ebreak are all 0; selects take their defaults (RS1/RS2/EX_RESULT).
- Storage: main register (drives outputs) and skid register. States EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE (load main).
  - ONE:
    - dec_ready_i & accept: reload main, stay in ONE.
    - dec_ready_i & no accept: -> EMPTY.
    - ~dec_ready_i & accept: load skid, -> TWO.
  - TWO: dec_ready_i: main<=skid, -> ONE.
- instr_ready_o = (state != TWO), driven from the state register only.
- flush_i: next state EMPTY regardless of other inputs. No acceptance in the flush cycle. Payload registers may hold stale values.
- Whenever dec_valid_o=0, all enable/flag outputs (gpr_we, mem_req, mem_we, csr_we, mdu_req, branch, jal, jalr, mret, ecall, ebreak, illegal) are forced to 0.
- Output stability: while dec_valid_o=1 & dec_ready_i=0, every output holds stable.
- Reset (async, rst_ni=0): state EMPTY; all registered outputs 0; instr_ready_o=1 after reset. Reset asserted mid-stream discards all entries.

Test Plan:
1. Reset, then 0x00500093 (addi x1,x0,5) with dec_ready_i=1 -> next cycle dec_valid_o=1, alu_op=ADD, b_sel=IMM_I, gpr_we=1, rd_addr_o=1, dec_pc_o=pc_i.
2. M_EXT_EN=1, 0x022081B3 (mul) -> mdu_req_o=1, mdu_op_o=0, wb_sel_o=3. With M_EXT_EN=0 -> illegal_instr_o=1, gpr_we_o=0.
3. Back-pressure: dec_ready_i=0, stream 0x0000A283 (lw) then 0x002081B3 (add) -> state TWO, instr_ready_o=0, outputs hold lw (mem_size=LDST_W, wb_sel=1). dec_ready_i=1 -> add appears next cycle, instr_ready_o=1 again. No entry lost or duplicated.
4. flush_i asserted in state TWO with instr_valid_i=1 -> dec_valid_o=0 next cycle, all enables 0, the offered instruction is not accepted.
5. 0x00000073, 0x00100073, 0x30200073, 0x10500073 -> ecall_o, ebreak_o, mret_o, illegal_instr_o respectively. CSR_EN=0 with 0x30001073 -> illegal, csr_we_o=0.
6. rst_ni low for part of a cycle while dec_valid_o=1 -> outputs clear immediately, without waiting for a clock edge. After release, instr_ready_o=1 and dec_valid_o=0.
